// File: rtl/vga_stream_display_pkg.sv
// Shared types and default 640x480@60 timing for the VGA stream display.
// Holds the registered output bundle type and its reset value.
package vga_stream_display_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Both syncs are active low for this mode.
    localparam logic SYNC_POL = 1'b0;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic       frame_start;
        logic [3:0] gray;
    } vga_out_t;

    localparam vga_out_t VGA_OUT_RST = '{
        hsync:       ~SYNC_POL,
        vsync:       ~SYNC_POL,
        de:          1'b0,
        frame_start: 1'b0,
        gray:        4'h0
    };

endpackage

// File: rtl/vga_stream_display_if.sv
// Valid/ready pixel stream carrying 8-bit grayscale samples.
// master drives data_valid/data, slave drives data_ready.
interface vga_stream_display_if;

    logic       data_valid;
    logic [7:0] data;
    logic       data_ready;

    modport master (
        output data_valid,
        output data,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data,
        output data_ready
    );

endinterface

// File: rtl/vga_stream_display_pixel_fifo.sv
// Synchronous pixel FIFO, power-of-2 depth, head read from storage.
// Ports: clk/rst, push/din, pop, head, count, ready (registered not-full).
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        // Ready follows the post-update count, so a pop at full
        // only reopens the input on the following cycle.
        ready_d = count_d < CW'(DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign ready = ready_q;

endmodule

// File: rtl/vga_stream_display.sv
// VGA timing generator that displays a buffered grayscale pixel stream.
// Ports: i_clk/i_rst, s_in (pixel stream slave), VGA sync/DE/RGB, frame_start, underflow.
module vga_stream_display
    import vga_stream_display_pkg::*;
#(
    parameter int         H_ACTIVE   = H_ACTIVE_DEF,
    parameter int         H_FP       = H_FP_DEF,
    parameter int         H_SYNC     = H_SYNC_DEF,
    parameter int         H_BP       = H_BP_DEF,
    parameter int         V_ACTIVE   = V_ACTIVE_DEF,
    parameter int         V_FP       = V_FP_DEF,
    parameter int         V_SYNC     = V_SYNC_DEF,
    parameter int         V_BP       = V_BP_DEF,
    parameter int         IMG_W      = 512,
    parameter int         IMG_H      = 512,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] BORDER_VAL = 8'h00
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    vga_stream_display_if.slave  s_in,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_de,
    output logic [3:0]           o_vga_r,
    output logic [3:0]           o_vga_g,
    output logic [3:0]           o_vga_b,
    output logic                 o_frame_start,
    output logic                 o_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // Image rows/cols beyond the visible area are never fetched.
    localparam int IMG_W_C = (IMG_W < H_ACTIVE) ? IMG_W : H_ACTIVE;
    localparam int IMG_H_C = (IMG_H < V_ACTIVE) ? IMG_H : V_ACTIVE;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    vga_out_t      out_q, out_d;
    logic          uf_q, uf_d;

    logic                        visible, in_img;
    logic                        hs_on, vs_on;
    logic                        push, pop, empty, fifo_ready;
    logic [7:0]                  head, pixel;
    logic [$clog2(FIFO_DEPTH):0] count;

    assign push  = s_in.data_valid && fifo_ready;
    assign empty = (count == '0);
    assign pop   = in_img && !empty;

    pixel_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .din   (s_in.data),
        .pop   (pop),
        .head  (head),
        .count (count),
        .ready (fifo_ready)
    );

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    always_comb begin
        visible = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        in_img  = visible && (h_q < HW'(IMG_W_C)) && (v_q < VW'(IMG_H_C));
        hs_on   = (h_q >= HW'(H_ACTIVE + H_FP)) &&
                  (h_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_on   = (v_q >= VW'(V_ACTIVE + V_FP)) &&
                  (v_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
        // A starved image slot shows the border and is not replayed.
        pixel   = pop ? head : BORDER_VAL;

        out_d             = VGA_OUT_RST;
        out_d.hsync       = hs_on ? SYNC_POL : ~SYNC_POL;
        out_d.vsync       = vs_on ? SYNC_POL : ~SYNC_POL;
        out_d.de          = visible;
        out_d.frame_start = (h_q == '0) && (v_q == '0);
        out_d.gray        = visible ? pixel[7:4] : 4'h0;

        uf_d = uf_q || (in_img && empty);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q   <= '0;
            v_q   <= '0;
            out_q <= VGA_OUT_RST;
            uf_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            out_q <= out_d;
            uf_q  <= uf_d;
        end
    end

    assign s_in.data_ready = fifo_ready;
    assign o_hsync         = out_q.hsync;
    assign o_vsync         = out_q.vsync;
    assign o_de            = out_q.de;
    assign o_vga_r         = out_q.gray;
    assign o_vga_g         = out_q.gray;
    assign o_vga_b         = out_q.gray;
    assign o_frame_start   = out_q.frame_start;
    assign o_underflow     = uf_q;

endmodule
